// File: rtl/diff_in_failover_pkg.sv
// Shared types and defaults for the differential-input failover monitor.
// cnt_w() sizes the counters that must hold values up to n.
package diff_in_failover_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_PRI,
        ST_SEC,
        ST_HOLD,
        ST_FLT
    } state_t;

    localparam int DEF_WINDOW      = 256;
    localparam int DEF_MIN_EDGES   = 8;
    localparam int DEF_INVALID_MAX = 4;
    localparam int DEF_HOLDOFF     = 16;
    localparam int DEF_REVERT      = 1;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/diff_lane_mon.sv
// Per-lane health monitor: synchronizes O/OB, counts O edges and flags invalid (O==OB) runs.
// ok_now is the lane verdict including this cycle's events, sampled by the top at window end.
module diff_lane_mon
    import diff_in_failover_pkg::*;
#(
    parameter int MIN_EDGES   = DEF_MIN_EDGES,
    parameter int INVALID_MAX = DEF_INVALID_MAX
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic o,
    input  logic ob,
    input  logic we,
    output logic ok_now
);

    localparam int EW = cnt_w(MIN_EDGES);
    localparam int IW = cnt_w(INVALID_MAX);
    localparam logic [EW-1:0] EDGE_SAT = EW'(MIN_EDGES);
    localparam logic [IW-1:0] RUN_SAT  = IW'(INVALID_MAX);

    logic [1:0]    o_sync;
    logic [1:0]    ob_sync;
    logic          o_q;
    logic [EW-1:0] edges;
    logic [EW-1:0] edges_nx;
    logic [IW-1:0] run;
    logic [IW-1:0] run_nx;
    logic          invalid_seen;
    logic          invalid_now;
    logic          edge_hit;
    logic          same;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            o_sync       <= '0;
            ob_sync      <= '0;
            o_q          <= 1'b0;
            edges        <= '0;
            run          <= '0;
            invalid_seen <= 1'b0;
        end else begin
            o_sync       <= {o_sync[0], o};
            ob_sync      <= {ob_sync[0], ob};
            o_q          <= o_sync[1];
            run          <= run_nx;
            // The window-end verdict already includes this cycle, so start the new window empty.
            edges        <= we ? '0 : edges_nx;
            invalid_seen <= we ? 1'b0 : invalid_now;
        end
    end

    always_comb begin
        edge_hit = o_sync[1] ^ o_q;
        same     = (o_sync[1] == ob_sync[1]);

        edges_nx = edges;
        if (edge_hit && (edges != EDGE_SAT)) edges_nx = edges + 1'b1;

        run_nx = '0;
        if (same) run_nx = (run == RUN_SAT) ? run : run + 1'b1;

        invalid_now = invalid_seen || (run_nx == RUN_SAT);
        ok_now      = (edges_nx >= EDGE_SAT) && !invalid_now;
    end

endmodule

// File: rtl/diff_in_failover.sv
// Two-lane differential input failover: windowed lane health, selection FSM with hold-off.
//  state | meaning
//  INIT  | after reset, waiting for the first window verdict
//  PRI   | lane 0 selected and healthy
//  SEC   | lane 1 selected and healthy
//  HOLD  | unlocked for HOLDOFF cycles before applying target lane
//  FLT   | no healthy lane, selection frozen
module diff_in_failover
    import diff_in_failover_pkg::*;
#(
    parameter int WINDOW      = DEF_WINDOW,
    parameter int MIN_EDGES   = DEF_MIN_EDGES,
    parameter int INVALID_MAX = DEF_INVALID_MAX,
    parameter int HOLDOFF     = DEF_HOLDOFF,
    parameter int REVERT      = DEF_REVERT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       O0,
    input  logic       OB0,
    input  logic       O1,
    input  logic       OB1,
    output logic       SEL,
    output logic       LOCKED,
    output logic       FAULT,
    output logic [1:0] LANE_OK,
    output logic [7:0] SWITCHES
);

    localparam int WW = cnt_w(WINDOW - 1);
    localparam int HW = cnt_w(HOLDOFF);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

    logic [WW-1:0] win_cnt;
    logic          we;
    logic          we_d;
    logic          ok_now0;
    logic          ok_now1;

    state_t        state, state_nx;
    logic          target, target_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          sel_nx;
    logic          locked_nx;
    logic          fault_nx;
    logic [7:0]    switches_nx;
    logic          enter_hold;
    logic          hold_tgt;

    diff_lane_mon #(.MIN_EDGES(MIN_EDGES), .INVALID_MAX(INVALID_MAX)) u_lane0 (
        .clk_sys(CLK), .rst_b(RST_N), .o(O0), .ob(OB0), .we(we), .ok_now(ok_now0)
    );

    diff_lane_mon #(.MIN_EDGES(MIN_EDGES), .INVALID_MAX(INVALID_MAX)) u_lane1 (
        .clk_sys(CLK), .rst_b(RST_N), .o(O1), .ob(OB1), .we(we), .ok_now(ok_now1)
    );

    assign we = (win_cnt == WIN_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            win_cnt  <= '0;
            we_d     <= 1'b0;
            LANE_OK  <= 2'b00;
            state    <= ST_INIT;
            target   <= 1'b0;
            hold_cnt <= '0;
            SEL      <= 1'b0;
            LOCKED   <= 1'b0;
            FAULT    <= 1'b0;
            SWITCHES <= '0;
        end else begin
            win_cnt  <= we ? '0 : win_cnt + 1'b1;
            we_d     <= we;
            if (we) LANE_OK <= {ok_now1, ok_now0};
            state    <= state_nx;
            target   <= target_nx;
            hold_cnt <= hold_nx;
            SEL      <= sel_nx;
            LOCKED   <= locked_nx;
            FAULT    <= fault_nx;
            SWITCHES <= switches_nx;
        end
    end

    // Health-driven transitions fire only on the cycle after window end, when LANE_OK is fresh.
    always_comb begin
        state_nx    = state;
        target_nx   = target;
        hold_nx     = hold_cnt;
        sel_nx      = SEL;
        locked_nx   = LOCKED;
        fault_nx    = FAULT;
        switches_nx = SWITCHES;
        enter_hold  = 1'b0;
        hold_tgt    = 1'b0;

        case (state)
            ST_INIT: begin
                if (we_d) begin
                    if (LANE_OK[0]) begin
                        state_nx  = ST_PRI;
                        locked_nx = 1'b1;
                    end else if (LANE_OK[1]) begin
                        enter_hold = 1'b1;
                        hold_tgt   = 1'b1;
                    end else begin
                        state_nx = ST_FLT;
                        fault_nx = 1'b1;
                    end
                end
            end
            ST_PRI: begin
                if (we_d && !LANE_OK[0]) begin
                    if (LANE_OK[1]) begin
                        enter_hold = 1'b1;
                        hold_tgt   = 1'b1;
                    end else begin
                        state_nx  = ST_FLT;
                        locked_nx = 1'b0;
                        fault_nx  = 1'b1;
                    end
                end
            end
            ST_SEC: begin
                if (we_d) begin
                    if (LANE_OK[0] && ((REVERT != 0) || !LANE_OK[1])) begin
                        enter_hold = 1'b1;
                        hold_tgt   = 1'b0;
                    end else if (!LANE_OK[0] && !LANE_OK[1]) begin
                        state_nx  = ST_FLT;
                        locked_nx = 1'b0;
                        fault_nx  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nx  = target ? ST_SEC : ST_PRI;
                    sel_nx    = target;
                    locked_nx = 1'b1;
                    if ((target != SEL) && (SWITCHES != 8'hFF)) switches_nx = SWITCHES + 8'd1;
                end else begin
                    hold_nx = hold_cnt - 1'b1;
                end
            end
            ST_FLT: begin
                if (we_d) begin
                    if (LANE_OK[0]) begin
                        enter_hold = 1'b1;
                        hold_tgt   = 1'b0;
                    end else if (LANE_OK[1]) begin
                        enter_hold = 1'b1;
                        hold_tgt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nx  = ST_INIT;
                locked_nx = 1'b0;
                fault_nx  = 1'b0;
            end
        endcase

        if (enter_hold) begin
            state_nx  = ST_HOLD;
            target_nx = hold_tgt;
            hold_nx   = HOLD_LOAD;
            locked_nx = 1'b0;
            fault_nx  = 1'b0;
        end
    end

endmodule
